// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, DATA_W data bits LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) between data and stop.
module uart_tx_cfg #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 13021,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    , parameter int PARITY_ODD = 0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              tx
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_cfg: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  baud, baud_n;
    logic [BIT_W-1:0]  bitcnt, bitcnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              tx_n;
    logic              tick;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign ready = (state == IDLE) && en;
    assign busy  = (state != IDLE);
    assign tick  = en && (state != IDLE) && (baud == BAUD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            tx     <= tx_n;
`ifdef UART_TX_PARITY_EN
            par    <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        tx_n     = tx;
        done     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        if (en && state != IDLE)
            baud_n = tick ? '0 : baud + 1'b1;
        if (en) begin
            case (state)
                IDLE: if (valid) begin
                    shreg_n = data;
                    state_n = START;
                    tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^data) ^ (PARITY_ODD != 0);
`endif
                end
                START: if (tick) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    tx_n     = shreg[0];
                end
                DATA: if (tick) begin
                    if (bitcnt == LAST_DATA) begin
                        bitcnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n  = PARITY;
                        tx_n     = par;
`else
                        state_n  = STOP;
                        tx_n     = 1'b1;
`endif
                    end else begin
                        // Shift so the next bit sits at [0]; present it on tx now.
                        bitcnt_n = bitcnt + 1'b1;
                        shreg_n  = shreg >> 1;
                        tx_n     = shreg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (bitcnt == LAST_STOP) begin
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        done     = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                    tx_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: two instances (8N1 and 5-bit/2-stop), frames checked per cycle.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst, en, sel, v;
    logic [8:0] d;
    logic [7:0] data8;
    logic [4:0] data5;
    logic valid8, ready8, busy8, done8, tx8;
    logic valid5, ready5, busy5, done5, tx5;
    logic txm, busym, donem, rdym;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign data8  = d[7:0];
    assign data5  = d[4:0];
    assign valid8 = v & ~sel;
    assign valid5 = v & sel;
    assign txm    = sel ? tx5 : tx8;
    assign busym  = sel ? busy5 : busy8;
    assign donem  = sel ? done5 : done8;
    assign rdym   = sel ? ready5 : ready8;

    uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(0)
`endif
    ) dut (.clk(clk), .rst(rst), .en(en), .data(data8), .valid(valid8),
           .ready(ready8), .busy(busy8), .done(done8), .tx(tx8));

    uart_tx_cfg #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1)
`endif
    ) dut5 (.clk(clk), .rst(rst), .en(en), .data(data5), .valid(valid5),
            .ready(ready5), .busy(busy5), .done(done5), .tx(tx5));

    // Reference: expected line level per bit period, built from the frame format.
    task automatic frame(input string name, input logic [8:0] dd, input bit tog,
                         input bit hold, input logic [8:0] nd);
        int w = sel ? 5 : 8;
        int s = sel ? 2 : 1;
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < w; i++) q.push_back(dd[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back((^(dd & 9'((1 << w) - 1))) ^ sel);
`endif
        for (int i = 0; i < s; i++) q.push_back(1'b1);

        @(posedge clk); #1;
        en = 1'b1; v = 1'b1; d = dd;
        @(negedge clk);
        checks++;
        if (rdym !== 1'b1 || busym !== 1'b0 || txm !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: ready=%b busy=%b tx=%b, want 1 0 1", name, rdym, busym, txm);
        end
        for (int b = 0; b < q.size(); b++) begin
            for (int k = 0; k < CPB; k++) begin
                bit last;
                last = (b == q.size() - 1) && (k == CPB - 1);
                if (tog) begin
                    @(posedge clk); #1;
                    en = 1'b0; v = 1'($urandom_range(0, 1)); d = 9'($urandom);
                    @(negedge clk);
                    checks++;
                    if (txm !== q[b] || donem !== 1'b0 || rdym !== 1'b0 || busym !== 1'b1) begin
                        failures++;
                        $display("FAIL %s hold bit%0d: tx=%b done=%b ready=%b busy=%b, want %b 0 0 1",
                                 name, b, txm, donem, rdym, busym, q[b]);
                    end
                end
                @(posedge clk); #1;
                en = 1'b1;
                v  = hold ? 1'b1 : 1'($urandom_range(0, 1));
                d  = (last && hold) ? nd : 9'($urandom);
                @(negedge clk);
                checks++;
                if (txm !== q[b] || busym !== 1'b1 || rdym !== 1'b0) begin
                    failures++;
                    $display("FAIL %s bit%0d.%0d: tx=%b busy=%b ready=%b, want %b 1 0",
                             name, b, k, txm, busym, rdym, q[b]);
                end
                checks++;
                if (donem !== last) begin
                    failures++;
                    $display("FAIL %s done bit%0d.%0d: got %b want %b", name, b, k, donem, last);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; v = 1'b0; d = '0; sel = 1'b0;
        #3;
        checks++;
        if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || ready8 !== 1'b0) begin
            failures++;
            $display("FAIL reset: tx=%b busy=%b done=%b ready=%b, want 1 0 0 0", tx8, busy8, done8, ready8);
        end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; en = 1'b1;
        @(negedge clk);
        checks++;
        if (ready8 !== 1'b1 || ready5 !== 1'b1 || tx5 !== 1'b1 || busy5 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready8=%b ready5=%b tx5=%b busy5=%b, want 1 1 1 0",
                     ready8, ready5, tx5, busy5);
        end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        frame("a5", 9'h0A5, 1'b0, 1'b0, 9'h0);
        frame("07", 9'h007, 1'b0, 1'b0, 9'h0);
        repeat (3) frame("rand8", 9'($urandom_range(0, 255)), 1'b0, 1'b0, 9'h0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        frame("b2b_55", 9'h055, 1'b0, 1'b1, 9'h0AA);
        frame("b2b_aa", 9'h0AA, 1'b0, 1'b0, 9'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; v = 1'b0;
            @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || tx8 !== 1'b1) begin
                failures++;
                $display("FAIL b2b_after: busy=%b tx=%b, want 0 1", busy8, tx8);
            end
        end
    endtask

    task automatic test_en_toggle();
        sel = 1'b0;
        frame("en_3c", 9'h03C, 1'b1, 1'b0, 9'h0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(posedge clk); #1; en = 1'b1; v = 1'b1; d = 9'h0F0;
        @(posedge clk); #1; v = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        checks++;
        if (busy8 !== 1'b1 || tx8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_pre: busy=%b tx=%b, want 1 0", busy8, tx8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: tx=%b busy=%b done=%b, want 1 0 0", tx8, busy8, done8);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready8 !== 1'b1 || tx8 !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready: ready=%b tx=%b, want 1 1", ready8, tx8);
        end
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || tx8 !== 1'b1) begin
                failures++;
                $display("FAIL mid_after: done=%b busy=%b tx=%b, want 0 0 1", done8, busy8, tx8);
            end
        end
    endtask

    task automatic test_w5();
        sel = 1'b1;
        frame("w5_1f", 9'h01F, 1'b0, 1'b0, 9'h0);
        frame("w5_07", 9'h007, 1'b0, 1'b0, 9'h0);
        repeat (2) frame("w5_rand", 9'($urandom_range(0, 31)), 1'b0, 1'b0, 9'h0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_en_toggle();
        test_reset_mid();
        test_w5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
